// File: rtl/sort_pkg.sv
// Shared definitions for the sort arbiter slice: element width, FSM state
// encoding and the helper that locates a requester's vector in the packed bus.
package sort_pkg;

   localparam int ELEM_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } arb_state_t;

   // Bit offset of requester k's vector inside a packed NREQ*N*ELEM_W bus.
   function automatic int slice_base(input int k, input int n);
      return k * n * ELEM_W;
   endfunction

endpackage

// File: rtl/sort_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request found searching
// upward from the pointer, wrapping at NREQ. Outputs are one-hot grant plus
// the binary winner index; the owning FSM registers both.
module rr_arbiter
   import sort_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx,
   output logic            any
);

   int pos;

   // Walk the requesters in priority order starting at ptr; first hit wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = 0;
      for (int off = 0; off < NREQ; off++) begin
         pos = (int'(ptr) + off) % NREQ;
         if (!any && req[pos]) begin
            any      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = PW'(pos);
         end
      end
   end

endmodule

// File: rtl/sort_arbiter.sv
// Round-robin front end that shares one selection-sort engine between NREQ
// requesters: pick a winner, load its vector, pulse start, wait for done and
// return the sorted vector with a one-cycle valid to the winner.
// Optional build macro SORT_ARB_TIMEOUT_EN adds a WAIT watchdog that returns
// the unsorted input with err=1 after TIMEOUT_CYCLES cycles without done.
module sort_arbiter
   import sort_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int N              = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*N*ELEM_W-1:0] req_data,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          resp_valid,
   output logic [N*ELEM_W-1:0]      resp_data,
   output logic                     busy,
   output logic                     err,
   output logic                     eng_start,
   output logic [N*ELEM_W-1:0]      eng_data_in,
   input  logic [N*ELEM_W-1:0]      eng_data_out,
   input  logic                     eng_done
);

   localparam int VW = N * ELEM_W;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] rv_q, rv_d;
   logic [VW-1:0]   rdata_q, rdata_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;
   logic [VW-1:0]   ein_q, ein_d;
   logic [PW-1:0]   win_q, win_d;
   logic [PW-1:0]   ptr_q, ptr_d;

   logic [NREQ-1:0] arb_gnt;
   logic [PW-1:0]   arb_idx;
   logic            arb_any;

`ifdef SORT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .req  (req),
      .ptr  (ptr_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx),
      .any  (arb_any)
   );

   // Next state plus next value of every registered output.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rv_d    = '0;
      rdata_d = rdata_q;
      start_d = 1'b0;
      ein_d   = ein_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
`ifdef SORT_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // req is only looked at here; mid-service changes are ignored.
            if (arb_any) begin
               state_d = S_LOAD;
               grant_d = arb_gnt;
               win_d   = arb_idx;
               ein_d   = req_data[slice_base(int'(arb_idx), N) +: VW];
               start_d = 1'b1;
            end
         end
         S_LOAD: begin
            state_d = S_WAIT;
`ifdef SORT_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            // The engine drops done on the start edge, so any done seen
            // here belongs to the current job.
            if (eng_done) begin
               state_d = S_RESP;
               rdata_d = eng_data_out;
               rv_d    = grant_q;
            end
`ifdef SORT_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
               state_d = S_RESP;
               rdata_d = ein_q;
               rv_d    = grant_q;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
`endif
         end
         S_RESP: begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         rv_q    <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         ein_q   <= '0;
         win_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rv_q    <= rv_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         ein_q   <= ein_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef SORT_ARB_TIMEOUT_EN
   // Watchdog counter and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign grant       = grant_q;
   assign resp_valid  = rv_q;
   assign resp_data   = rdata_q;
   assign busy        = busy_q;
   assign eng_start   = start_q;
   assign eng_data_in = ein_q;

endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter with a behavioural sort engine model
// (done visible N cycles after the start edge, optional never-done mode).
module tb_sort_arbiter;

   localparam int NREQ = 4;
   localparam int N    = 4;
   localparam int VW   = N * 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*VW-1:0]   req_data = '0;
   logic [NREQ-1:0]      grant, resp_valid;
   logic [VW-1:0]        resp_data, eng_data_in, eng_data_out;
   logic                 busy, err, eng_start, eng_done;

   int nvec = 0;
   int nmis = 0;

   // engine model state (no reset, like the real engine)
   logic [VW-1:0] eng_q    = '0;
   logic          eng_dq   = 1'b0;
   int            eng_cnt  = 0;
   bit            hang     = 1'b0;

   always #5 clk = ~clk;

   sort_arbiter #(
      .NREQ           (NREQ),
      .N              (N),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .grant        (grant),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .busy         (busy),
      .err          (err),
      .eng_start    (eng_start),
      .eng_data_in  (eng_data_in),
      .eng_data_out (eng_data_out),
      .eng_done     (eng_done)
   );

   function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] v);
      logic [7:0]    e [N];
      logic [7:0]    t;
      logic [VW-1:0] r;
      for (int i = 0; i < N; i++) e[i] = v[i*8 +: 8];
      for (int i = 0; i < N - 1; i++)
         for (int j = 0; j < N - 1 - i; j++)
            if (e[j] > e[j+1]) begin
               t = e[j]; e[j] = e[j+1]; e[j+1] = t;
            end
      for (int i = 0; i < N; i++) r[i*8 +: 8] = e[i];
      return r;
   endfunction

   // Engine: start reloads and clears done; done rises N edges later.
   always @(posedge clk) begin
      if (eng_start === 1'b1) begin
         eng_q   <= sort_vec(eng_data_in);
         eng_dq  <= 1'b0;
         eng_cnt <= N;
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1 && !hang) eng_dq <= 1'b1;
      end
   end
   assign eng_data_out = eng_q;
   assign eng_done     = eng_dq;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in cycle 0 (arbiter IDLE); returns at the negedge of
   // cycle 8, which is cycle 0 of a back-to-back job.
   task automatic job(input string tag, input logic [NREQ-1:0] rq, input int win,
                      input logic [VW-1:0] exp, input bit drop);
      logic [NREQ-1:0] oh;
      int starts;
      bit early_rv;
      oh = 4'b0001 << win;
      req = rq;
      @(negedge clk);                     // cycle 1
      chk({tag, ".grant"}, grant, oh);
      chk({tag, ".start"}, eng_start, 1'b1);
      chk({tag, ".busy"},  busy, 1'b1);
      starts   = 1;
      early_rv = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         @(negedge clk);
         if (eng_start) starts++;
         if (resp_valid != '0) early_rv = 1'b1;
      end
      chk({tag, ".starts"}, starts, 1);
      chk({tag, ".early_rv"}, early_rv, 1'b0);
      @(negedge clk);                     // cycle 7
      chk({tag, ".rv"},    resp_valid, oh);
      chk({tag, ".rdata"}, resp_data, exp);
      chk({tag, ".err"},   err, 1'b0);
      if (drop) req = req & ~oh;
      @(negedge clk);                     // cycle 8
      chk({tag, ".grant_off"}, grant, '0);
      chk({tag, ".rv_off"},    resp_valid, '0);
      chk({tag, ".idle"},      busy, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".grant"}, grant, '0);
      chk({tag, ".rv"},    resp_valid, '0);
      chk({tag, ".rdata"}, resp_data, '0);
      chk({tag, ".busy"},  busy, 1'b0);
      chk({tag, ".err"},   err, 1'b0);
      chk({tag, ".start"}, eng_start, 1'b0);
      chk({tag, ".ein"},   eng_data_in, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // single job, requester 2
      req_data[2*VW +: VW] = 32'h09030701;
      job("single", 4'b0100, 2, 32'h09070301, 1'b1);
      chk("single.ein", eng_data_in, 32'h09030701);

      // pointer now 3: serve 3 (already sorted), then 1001 -> 0 beats 3
      req_data[3*VW +: VW] = 32'h04030201;
      req_data[0*VW +: VW] = 32'hFFFF0000;
      job("ptr3",   4'b1000, 3, 32'h04030201, 1'b1);
      job("wrap0",  4'b1001, 0, 32'hFFFF0000, 1'b1);
      job("wrap3",  req,     3, 32'h04030201, 1'b1);

      // round robin with all requests held, back-to-back every N+4 cycles
      req_data[0*VW +: VW] = 32'h10203040;
      req_data[1*VW +: VW] = 32'h01020304;
      req_data[2*VW +: VW] = 32'h55AA0033;
      req_data[3*VW +: VW] = 32'h7F807F80;
      job("rr0", 4'b1111, 0, 32'h40302010, 1'b0);
      job("rr1", 4'b1111, 1, 32'h04030201, 1'b0);
      job("rr2", 4'b1111, 2, 32'hAA553300, 1'b0);
      job("rr3", 4'b1111, 3, 32'h80807F7F, 1'b0);
      job("rr4", 4'b1111, 0, 32'h40302010, 1'b0);
      req = '0;
      @(negedge clk);

      // reset in cycle 4 (WAIT) of a job
      req = 4'b0001;
      @(negedge clk);
      chk("midrst.grant", grant, 4'b0001);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      rst = 1'b0;
      req = '0;
      repeat (3) @(negedge clk);         // stale engine done rises meanwhile
      chk("midrst.idle", busy, 1'b0);
      req_data[1*VW +: VW] = 32'hC0A0B0D0;
      job("postrst", 4'b0010, 1, 32'hD0C0B0A0, 1'b1);

`ifdef SORT_ARB_TIMEOUT_EN
      // engine never finishes: watchdog answers 10 cycles after grant
      hang = 1'b1;
      req_data[2*VW +: VW] = 32'h09030701;
      req = 4'b0100;
      @(negedge clk);                     // cycle 1
      chk("to.grant", grant, 4'b0100);
      repeat (9) @(negedge clk);          // cycle 10
      chk("to.rv_early", resp_valid, '0);
      @(negedge clk);                     // cycle 11
      chk("to.rv",    resp_valid, 4'b0100);
      chk("to.err",   err, 1'b1);
      chk("to.rdata", resp_data, 32'h09030701);
      req = '0;
      @(negedge clk);
      chk("to.err_off", err, 1'b0);
      chk("to.idle",    busy, 1'b0);
      hang = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
